regfile_sb: RTL and testbench

- Parametrised successor to the team's 16x16 register file.
- Keeps the two combinational read ports, one write port and hard-wired register 0.
- Generalises data width and register count.
- Adds an integrated scoreboard of per-register busy bits. The issue stage marks destinations pending and the write-back stage clears them, so RAW/WAW hazard detection lives next to the storage.

---
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one write-back port, hard-wired zero register and a per-register busy
// scoreboard (issue marks pending, write-back clears).
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write-back data to
// the read ports and lets an issue claim a register being written back.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic                iss_ready,
  output logic [NUM_REGS-1:0] busy_vec
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_hit;
  logic                iss_fire;

  // True for addresses that name a real, writable register (not r0, not out of range).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REG_LIMIT) && (a != '0);
  endfunction

  assign wr_hit   = wr_en && addr_ok(wr_addr);
  assign iss_fire = iss_en && iss_ready && addr_ok(iss_addr);
  assign busy_vec = busy;

  // Storage and scoreboard update; the issue set follows the write-back clear
  // so a same-register collision leaves the busy bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_hit) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (iss_fire) begin
        busy[iss_addr] <= 1'b1;
      end
    end
  end

  // Read port 1: zero for r0 and out-of-range addresses.
  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    if (addr_ok(rd_addr1)) begin
      rd_data1 = regs[rd_addr1];
      rd_busy1 = busy[rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
        rd_busy1 = 1'b0;
      end
`endif
    end
  end

  // Read port 2: zero for r0 and out-of-range addresses.
  always_comb begin
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    if (addr_ok(rd_addr2)) begin
      rd_data2 = regs[rd_addr2];
      rd_busy2 = busy[rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
        rd_busy2 = 1'b0;
      end
`endif
    end
  end

  // Issue readiness from the pre-edge busy bit; r0 and invalid addresses are always ready.
  always_comb begin
    iss_ready = 1'b1;
    if (addr_ok(iss_addr)) begin
      iss_ready = ~busy[iss_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == iss_addr)) begin
        iss_ready = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test-plan steps followed by randomized traffic,
// all checked against an array-based reference model of the register file.
module tb_regfile_sb;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [ADDR_W-1:0]   rd_addr1, rd_addr2;
  logic [DATA_W-1:0]   rd_data1, rd_data2;
  logic                rd_busy1, rd_busy2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                iss_en;
  logic [ADDR_W-1:0]   iss_addr;
  logic                iss_ready;
  logic [NUM_REGS-1:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] m_data [NUM_REGS];
  bit                m_busy [NUM_REGS];

  regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .busy_vec(busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writable(input int a);
    return (a > 0) && (a < NUM_REGS);
  endfunction

  function automatic bit write_now(input int a);
    return wr_en && writable(int'(wr_addr)) && (int'(wr_addr) == a);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!writable(a)) return '0;
    if (BYP && write_now(a)) return wr_data;
    return m_data[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (!writable(a)) return 1'b0;
    if (BYP && write_now(a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit exp_ready();
    int a = int'(iss_addr);
    if (!writable(a)) return 1'b1;
    if (BYP && write_now(a)) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_vec();
    logic [NUM_REGS-1:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".rd_data1"}, 32'(rd_data1), 32'(exp_data(int'(rd_addr1))));
    check({where, ".rd_data2"}, 32'(rd_data2), 32'(exp_data(int'(rd_addr2))));
    check({where, ".rd_busy1"}, 32'(rd_busy1), 32'(exp_busy(int'(rd_addr1))));
    check({where, ".rd_busy2"}, 32'(rd_busy2), 32'(exp_busy(int'(rd_addr2))));
    check({where, ".iss_ready"}, 32'(iss_ready), 32'(exp_ready()));
    check({where, ".busy_vec"}, 32'(busy_vec), 32'(exp_vec()));
  endtask

  task automatic drive(input string where, input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic ie, input logic [ADDR_W-1:0] ia,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr1 = r1; rd_addr2 = r2;
    #1;
    check_all(where);
  endtask

  // Advance one edge and apply the architectural rules to the model.
  task automatic tick();
    bit ready = exp_ready();
    @(posedge clk);
    if (wr_en && writable(int'(wr_addr))) begin
      m_data[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (iss_en && ready && writable(int'(iss_addr))) m_busy[iss_addr] = 1'b1;
    #1;
  endtask

  task automatic async_reset(input string where);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    check({where, ".busy_zero"}, 32'(busy_vec), 32'h0);
    check({where, ".data1_zero"}, 32'(rd_data1), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    rd_addr1 = 4'd1; rd_addr2 = 4'd2;
    model_reset();

    // Reset asserted between edges
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    check("reset.busy_vec", 32'(busy_vec), 32'h0);
    #4 rst_n = 1'b1;

    // Basic write then read
    drive("wr5", 1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    drive("rd5", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    check("rd5.const_data", 32'(rd_data1), 32'h0000_A5A5);
    check("rd5.const_busy", 32'(rd_busy1), 32'h0);

    // Register 0 ignores write and issue
    drive("r0", 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
    check("r0.iss_ready", 32'(iss_ready), 32'h1);
    tick();
    drive("r0_after", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("r0.data", 32'(rd_data1), 32'h0);
    check("r0.busy0", 32'(busy_vec[0]), 32'h0);

    // Scoreboard mark, dropped repeat, write-back clear
    drive("iss3", 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd0, 4'd3);
    tick();
    check("iss3.busy_vec", 32'(busy_vec), 32'h0008);
    check("iss3.rd_busy2", 32'(rd_busy2), 32'h1);
    check("iss3.ready_again", 32'(iss_ready), 32'h0);
    tick();
    check("iss3.dropped", 32'(busy_vec), 32'h0008);
    drive("wb3", 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd0, 4'd3);
    tick();
    check("wb3.busy_vec", 32'(busy_vec), 32'h0);
    check("wb3.rd_data2", 32'(rd_data2), 32'h0000_1234);

    // Write-back/issue collision on a busy register
    drive("iss7", 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd0);
    tick();
    drive("coll7", 1'b1, 4'd7, 16'h0042, 1'b1, 4'd7, 4'd7, 4'd0);
    check("coll7.iss_ready", 32'(iss_ready), 32'(BYP));
    tick();
    drive("coll7_after", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd0);
    check("coll7.busy7", 32'(busy_vec[7]), 32'(BYP));
    check("coll7.data", 32'(rd_data1), 32'h0000_0042);

    // Same-cycle write and read of register 9
    drive("byp9", 1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 4'd9, 4'd9);
    check("byp9.same_cycle", 32'(rd_data1), BYP ? 32'h0000_BEEF : 32'h0);
    tick();
    drive("byp9_next", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd0);
    check("byp9.next_cycle", 32'(rd_data1), 32'h0000_BEEF);

    // Reset mid-operation, then normal behaviour on the first edge
    drive("pre_rst", 1'b1, 4'd4, 16'h5555, 1'b1, 4'd6, 4'd4, 4'd6);
    async_reset("midreset");
    drive("post_rst", 1'b1, 4'd4, 16'h7777, 1'b1, 4'd6, 4'd4, 4'd6);
    tick();
    check("post_rst.data4", 32'(rd_data1), 32'h0000_7777);
    check("post_rst.busy6", 32'(rd_busy2), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive("rand",
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, NUM_REGS - 1)),
            ADDR_W'($urandom_range(0, NUM_REGS - 1)), ADDR_W'($urandom_range(0, NUM_REGS - 1)));
      if ($urandom_range(0, 63) == 0) begin
        async_reset("rand_reset");
      end else begin
        tick();
        check_all("rand_post");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
